// File: rtl/ps2_line_buffer_if.sv
//------------------------------------------------------------------------------
// ps2_line_buffer_if : keystroke input / line and message output bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ps2_line_buffer_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 7
);
    logic                 key_valid;
    logic [7:0]           scancode;
    logic                 msg_ack;
    logic [8*DEPTH-1:0]   line_out;
    logic [CNT_W-1:0]     line_len;
    logic [8*DEPTH-1:0]   msg_out;
    logic [CNT_W-1:0]     msg_len;
    logic                 msg_valid;
    logic                 full;
    logic                 overflow;
    logic [7:0]           last_ascii;

    modport slave (
        input  key_valid, scancode, msg_ack,
        output line_out, line_len, msg_out, msg_len, msg_valid,
               full, overflow, last_ascii
    );

    modport master (
        output key_valid, scancode, msg_ack,
        input  line_out, line_len, msg_out, msg_len, msg_valid,
               full, overflow, last_ascii
    );
endinterface

`default_nettype wire

// File: rtl/ps2_line_buffer.sv
//------------------------------------------------------------------------------
// ps2_line_buffer : Set-2 scancode line editor with committed message hold.
// Optional macro PS2_LINEBUF_SHIFT_EN enables left/right shift for capitals.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_line_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 7
) (
    input  logic               clock,
    input  logic               RESETN,
    ps2_line_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BRK    = 2'd1,
        S_EXT    = 2'd2,
        S_EXTBRK = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [8*DEPTH-1:0]   line_q, line_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [8*DEPTH-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0]     mlen_q, mlen_d;
    logic                 mvalid_q, mvalid_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           last_q, last_d;
    logic [7:0]           ascii;
    logic                 is_letter;
`ifdef PS2_LINEBUF_SHIFT_EN
    logic                 shift_q, shift_d;
`endif

    // Set-2 make code to lowercase ASCII; 0 means unmapped
    always_comb begin
        ascii = 8'h00;
        case (bus.scancode)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;  8'h29: ascii = 8'h20;
            default: ascii = 8'h00;
        endcase
        is_letter = (ascii >= 8'h61) && (ascii <= 8'h7A);
`ifdef PS2_LINEBUF_SHIFT_EN
        if (shift_q && is_letter) ascii = ascii - 8'd32;
`endif
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        len_d    = len_q;
        msg_d    = msg_q;
        mlen_d   = mlen_q;
        mvalid_d = mvalid_q;
        ovf_d    = ovf_q;
        last_d   = last_q;
`ifdef PS2_LINEBUF_SHIFT_EN
        shift_d  = shift_q;
`endif
        if (bus.msg_ack) mvalid_d = 1'b0;

        if (bus.key_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.scancode == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (bus.scancode == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (ascii != 8'h00) begin
                        if (len_q == CNT_W'(DEPTH)) begin
                            ovf_d = 1'b1;
                        end else begin
                            for (int i = 0; i < DEPTH; i++)
                                if (CNT_W'(i) == len_q) line_d[8*DEPTH-1-8*i -: 8] = ascii;
                            len_d  = len_q + CNT_W'(1);
                            last_d = ascii;
                        end
                    end else if (bus.scancode == 8'h66) begin
                        if (len_q != '0) begin
                            for (int i = 0; i < DEPTH; i++)
                                if (CNT_W'(i + 1) == len_q) line_d[8*DEPTH-1-8*i -: 8] = 8'h00;
                            len_d = len_q - CNT_W'(1);
                        end
                    end else if (bus.scancode == 8'h5A) begin
                        // An ack in the same cycle frees the holding slot for this commit
                        if (!mvalid_q || bus.msg_ack) begin
                            msg_d    = line_q;
                            mlen_d   = len_q;
                            mvalid_d = 1'b1;
                            line_d   = '0;
                            len_d    = '0;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (bus.scancode == 8'h76) begin
                        line_d = '0;
                        len_d  = '0;
                    end
`ifdef PS2_LINEBUF_SHIFT_EN
                    else if (bus.scancode == 8'h12 || bus.scancode == 8'h59) begin
                        shift_d = 1'b1;
                    end
`endif
                end
                S_BRK: begin
                    state_d = S_IDLE;
`ifdef PS2_LINEBUF_SHIFT_EN
                    if (bus.scancode == 8'h12 || bus.scancode == 8'h59) shift_d = 1'b0;
`endif
                end
                S_EXT:    state_d = (bus.scancode == 8'hF0) ? S_EXTBRK : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge RESETN) begin
        if (RESETN) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            len_q    <= '0;
            msg_q    <= '0;
            mlen_q   <= '0;
            mvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            last_q   <= 8'h00;
`ifdef PS2_LINEBUF_SHIFT_EN
            shift_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            len_q    <= len_d;
            msg_q    <= msg_d;
            mlen_q   <= mlen_d;
            mvalid_q <= mvalid_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
`ifdef PS2_LINEBUF_SHIFT_EN
            shift_q  <= shift_d;
`endif
        end
    end

    assign bus.line_out   = line_q;
    assign bus.line_len   = len_q;
    assign bus.msg_out    = msg_q;
    assign bus.msg_len    = mlen_q;
    assign bus.msg_valid  = mvalid_q;
    assign bus.full       = (len_q == CNT_W'(DEPTH));
    assign bus.overflow   = ovf_q;
    assign bus.last_ascii = last_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_line_buffer.sv
//------------------------------------------------------------------------------
// tb_ps2_line_buffer : directed table-driven bench for ps2_line_buffer (DEPTH=16)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_line_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 7;

    logic clock;
    logic RESETN;
    int   n_total;
    int   n_pass;

    ps2_line_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ps2_line_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .RESETN (RESETN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] code;
        logic [6:0] len;
        logic [7:0] last;
        logic       ovf;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] code, input logic ack);
        @(negedge clock);
        bus.key_valid = 1'b1;
        bus.scancode  = code;
        bus.msg_ack   = ack;
        @(negedge clock);
        bus.key_valid = 1'b0;
        bus.msg_ack   = 1'b0;
    endtask

    task automatic send_ack();
        @(negedge clock);
        bus.msg_ack = 1'b1;
        @(negedge clock);
        bus.msg_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        RESETN = 1'b1;
        @(negedge clock);
        RESETN = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        RESETN  = 1'b1;
        bus.key_valid = 1'b0;
        bus.scancode  = 8'h00;
        bus.msg_ack   = 1'b0;

        // "hello" with break codes, then Esc, then "ab" and three backspaces
        tbl[0]  = '{8'h33, 7'd1, 8'h68, 1'b0};
        tbl[1]  = '{8'hF0, 7'd1, 8'h68, 1'b0};
        tbl[2]  = '{8'h33, 7'd1, 8'h68, 1'b0};
        tbl[3]  = '{8'h24, 7'd2, 8'h65, 1'b0};
        tbl[4]  = '{8'hF0, 7'd2, 8'h65, 1'b0};
        tbl[5]  = '{8'h24, 7'd2, 8'h65, 1'b0};
        tbl[6]  = '{8'h4B, 7'd3, 8'h6C, 1'b0};
        tbl[7]  = '{8'hF0, 7'd3, 8'h6C, 1'b0};
        tbl[8]  = '{8'h4B, 7'd3, 8'h6C, 1'b0};
        tbl[9]  = '{8'h4B, 7'd4, 8'h6C, 1'b0};
        tbl[10] = '{8'hF0, 7'd4, 8'h6C, 1'b0};
        tbl[11] = '{8'h4B, 7'd4, 8'h6C, 1'b0};
        tbl[12] = '{8'h44, 7'd5, 8'h6F, 1'b0};
        tbl[13] = '{8'hF0, 7'd5, 8'h6F, 1'b0};
        tbl[14] = '{8'h44, 7'd5, 8'h6F, 1'b0};
        tbl[15] = '{8'h76, 7'd0, 8'h6F, 1'b0};
        tbl[16] = '{8'h1C, 7'd1, 8'h61, 1'b0};
        tbl[17] = '{8'h32, 7'd2, 8'h62, 1'b0};
        tbl[18] = '{8'h66, 7'd1, 8'h62, 1'b0};
        tbl[19] = '{8'h66, 7'd0, 8'h62, 1'b0};
        tbl[20] = '{8'h66, 7'd0, 8'h62, 1'b0};

        @(negedge clock);
        check("reset_line_out", bus.line_out, 128'h0);
        check("reset_line_len", 128'(bus.line_len), 128'h0);
        check("reset_msg_valid", 128'(bus.msg_valid), 128'h0);
        check("reset_full", 128'(bus.full), 128'h0);
        check("reset_overflow", 128'(bus.overflow), 128'h0);
        check("reset_last_ascii", 128'(bus.last_ascii), 128'h0);
        RESETN = 1'b0;

        for (int i = 0; i < 21; i++) begin
            send(tbl[i].code, 1'b0);
            check($sformatf("vec%0d_len", i), 128'(bus.line_len), 128'(tbl[i].len));
            check($sformatf("vec%0d_last", i), 128'(bus.last_ascii), 128'(tbl[i].last));
            check($sformatf("vec%0d_ovf", i), 128'(bus.overflow), 128'(tbl[i].ovf));
            if (i == 14) check("hello_line", bus.line_out, {40'h68656C6C6F, 88'h0});
            if (i == 20) check("bs_line_empty", bus.line_out, 128'h0);
        end

        // Full line: 17th append is dropped
        do_reset();
        for (int i = 0; i < 17; i++) send(8'h1C, 1'b0);
        check("full_flag", 128'(bus.full), 128'h1);
        check("full_len", 128'(bus.line_len), 128'd16);
        check("full_ovf", 128'(bus.overflow), 128'h1);
        check("full_slot15", 128'(bus.line_out[7:0]), 128'h61);
        send(8'h66, 1'b0);
        check("full_bs_len", 128'(bus.line_len), 128'd15);
        check("full_bs_full", 128'(bus.full), 128'h0);
        check("full_bs_slot15", 128'(bus.line_out[7:0]), 128'h0);

        // Commit, dropped commit, commit with simultaneous ack
        do_reset();
        send(8'h33, 1'b0);
        send(8'h43, 1'b0);
        send(8'h5A, 1'b0);
        check("c1_valid", 128'(bus.msg_valid), 128'h1);
        check("c1_mlen", 128'(bus.msg_len), 128'd2);
        check("c1_msg", bus.msg_out, {16'h6869, 112'h0});
        check("c1_len", 128'(bus.line_len), 128'd0);
        check("c1_line", bus.line_out, 128'h0);
        send(8'h22, 1'b0);
        send(8'h5A, 1'b0);
        check("c2_ovf", 128'(bus.overflow), 128'h1);
        check("c2_msg", bus.msg_out, {16'h6869, 112'h0});
        check("c2_line", bus.line_out, {8'h78, 120'h0});
        check("c2_len", 128'(bus.line_len), 128'd1);
        send(8'h5A, 1'b1);
        check("c3_msg", bus.msg_out, {8'h78, 120'h0});
        check("c3_valid", 128'(bus.msg_valid), 128'h1);
        check("c3_mlen", 128'(bus.msg_len), 128'd1);
        check("c3_len", 128'(bus.line_len), 128'd0);
        send_ack();
        check("ack_valid", 128'(bus.msg_valid), 128'h0);
        check("ack_msg_held", bus.msg_out, {8'h78, 120'h0});
        check("ack_mlen_held", 128'(bus.msg_len), 128'd1);
        send(8'h5A, 1'b0);
        check("empty_commit_valid", 128'(bus.msg_valid), 128'h1);
        check("empty_commit_mlen", 128'(bus.msg_len), 128'd0);

        // Extended and break sequences are ignored; reset mid break sequence
        do_reset();
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        check("ext_len", 128'(bus.line_len), 128'd0);
        check("ext_line", bus.line_out, 128'h0);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        check("brk_len", 128'(bus.line_len), 128'd0);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0);
        #2 RESETN = 1'b1;
        #2;
        check("async_rst_len", 128'(bus.line_len), 128'd0);
        check("async_rst_line", bus.line_out, 128'h0);
        @(negedge clock);
        RESETN = 1'b0;
        send(8'h1C, 1'b0);
        check("post_rst_len", 128'(bus.line_len), 128'd1);
        check("post_rst_line", bus.line_out, {8'h61, 120'h0});

        // Shift handling
        do_reset();
        send(8'h12, 1'b0);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h12, 1'b0);
        send(8'h1C, 1'b0);
`ifdef PS2_LINEBUF_SHIFT_EN
        check("shift_line", bus.line_out, {16'h4161, 112'h0});
`else
        check("shift_line", bus.line_out, {16'h6161, 112'h0});
`endif
        check("shift_len", 128'(bus.line_len), 128'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
